// File: rtl/regfile_writeback.sv
// Writeback stage for the 32x32 register file: ALU results take the single write
// port first, buffered load responses drain when it is free; tracks busy loads for stall.
module regfile_writeback #(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        issue_valid,
  input  logic        issue_is_load,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        dec_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic [4:0]  wr,
  output logic        write_enable,
  output logic [31:0] din
);

  localparam int unsigned AW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

  logic [4:0]    rd_mem   [LQ_DEPTH];
  logic [31:0]   data_mem [LQ_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   busy_q, busy_d;

  logic empty, full, push, pop, alu_wr;
  logic [4:0] head_rd;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign head_rd = rd_mem[rd_ptr_q];

  // Outputs are gated by rst so nothing leaks onto the port while reset is held.
  assign ld_ready  = rst & ~full;
  assign push      = ld_valid & ld_ready & (ld_rd != '0);
  assign alu_wr    = rst & alu_valid & (alu_rd != '0);
  assign pop       = rst & ~alu_wr & ~empty;
  assign dec_stall = rst & (busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd]);

  always_comb begin
    write_enable = 1'b0;
    wr           = '0;
    din          = '0;
    if (alu_wr) begin
      write_enable = 1'b1;
      wr           = alu_rd;
      din          = alu_data;
    end else if (pop) begin
      write_enable = 1'b1;
      wr           = head_rd;
      din          = data_mem[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Set is applied after clear so a same-cycle reissue to the draining register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (pop)
      busy_d[head_rd] = 1'b0;
    if (issue_valid && issue_is_load && (issue_rd != '0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= ld_rd;
      data_mem[wr_ptr_q] <= ld_data;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: each task drives one scenario and checks
// the write port, ld_ready and dec_stall against hand-computed values.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        issue_valid;
  logic        issue_is_load;
  logic [4:0]  issue_rd;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  wr;
  logic        write_enable;
  logic [31:0] din;

  int errors = 0;
  int checks = 0;

  regfile_writeback #(.LQ_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .issue_valid  (issue_valid),
    .issue_is_load(issue_is_load),
    .issue_rd     (issue_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .dec_stall    (dec_stall),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .wr           (wr),
    .write_enable (write_enable),
    .din          (din)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    issue_valid = 0; issue_is_load = 0; issue_rd = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic test_reset_initial();
    #2;
    checks++;
    if (write_enable !== 1'b0 || ld_ready !== 1'b0 || dec_stall !== 1'b0) begin
      errors++;
      $display("FAIL init_reset we=%0b ready=%0b stall=%0b exp 0/0/0", write_enable, ld_ready, dec_stall);
    end
    #10 rst = 1'b1;
    #1;
    checks++;
    if (ld_ready !== 1'b1 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL init_release ready=%0b we=%0b exp 1/0", ld_ready, write_enable);
    end
  endtask

  task automatic test_alu();
    next_cycle();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (write_enable !== 1'b1 || wr !== 5'd3 || din !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_write we=%0b wr=%0d din=%h exp 1/3/deadbeef", write_enable, wr, din);
    end
    next_cycle();
    alu_rd = 5'd0; alu_data = 32'h11111111;
    #1;
    checks++;
    if (write_enable !== 1'b0 || wr !== 5'd0 || din !== 32'd0) begin
      errors++;
      $display("FAIL alu_x0 we=%0b wr=%0d din=%h exp 0/0/0", write_enable, wr, din);
    end
    clear_inputs();
  endtask

  task automatic test_load_round_trip();
    next_cycle();
    issue_valid = 1; issue_is_load = 1; issue_rd = 5'd7;
    next_cycle();
    issue_valid = 0; issue_is_load = 0; issue_rd = '0;
    dec_rs2 = 5'd7;
    #1;
    checks++;
    if (dec_stall !== 1'b1 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL load_busy stall=%0b we=%0b exp 1/0", dec_stall, write_enable);
    end
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h12345678;
    #1;
    checks++;
    if (ld_ready !== 1'b1 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL load_offer ready=%0b we=%0b exp 1/0", ld_ready, write_enable);
    end
    next_cycle();
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    #1;
    checks++;
    if (write_enable !== 1'b1 || wr !== 5'd7 || din !== 32'h12345678 || dec_stall !== 1'b1) begin
      errors++;
      $display("FAIL load_write we=%0b wr=%0d din=%h stall=%0b exp 1/7/12345678/1",
               write_enable, wr, din, dec_stall);
    end
    next_cycle();
    #1;
    checks++;
    if (write_enable !== 1'b0 || dec_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_clear we=%0b stall=%0b exp 0/0", write_enable, dec_stall);
    end
    clear_inputs();
  endtask

  task automatic test_arbitration();
    logic [4:0]  exp_wr   [5];
    logic [31:0] exp_din  [5];
    logic        exp_rdy  [5];
    exp_wr  = '{5'd9, 5'd10, 5'd11, 5'd4, 5'd6};
    exp_din = '{32'h0000_0009, 32'h0000_000A, 32'h0000_000B, 32'hA4A4_A4A4, 32'hB6B6_B6B6};
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    next_cycle();
    ld_valid = 1; ld_rd = 5'd4; ld_data = 32'hA4A4_A4A4;
    next_cycle();
    ld_rd = 5'd6; ld_data = 32'hB6B6_B6B6;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        next_cycle();
        ld_valid = 0; ld_rd = '0; ld_data = '0;
      end
      alu_valid = (i < 3);
      alu_rd    = (i < 3) ? 5'(9 + i) : 5'd0;
      alu_data  = (i < 3) ? 32'(9 + i) : 32'd0;
      #1;
      checks++;
      if (write_enable !== 1'b1 || wr !== exp_wr[i] || din !== exp_din[i] || ld_ready !== exp_rdy[i]) begin
        errors++;
        $display("FAIL arb_cycle%0d we=%0b wr=%0d din=%h ready=%0b exp 1/%0d/%h/%0b",
                 i, write_enable, wr, din, ld_ready, exp_wr[i], exp_din[i], exp_rdy[i]);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (write_enable !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL arb_idle we=%0b ready=%0b exp 0/1", write_enable, ld_ready);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic       exp_rdy [6];
    logic       exp_we  [6];
    logic [4:0] exp_wr  [6];
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_we  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_wr  = '{5'd20, 5'd20, 5'd20, 5'd20, 5'd21, 5'd22};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      alu_valid = (i < 4); alu_rd = (i < 4) ? 5'd20 : 5'd0; alu_data = 32'h2020_2020;
      ld_valid = 1;
      ld_rd    = (i == 0) ? 5'd21 : (i == 1) ? 5'd22 : 5'd23;
      ld_data  = (i == 0) ? 32'hD1 : (i == 1) ? 32'hD2 : 32'hD3;
      #1;
      checks++;
      if (ld_ready !== exp_rdy[i] || write_enable !== exp_we[i] || wr !== exp_wr[i]) begin
        errors++;
        $display("FAIL full_cycle%0d ready=%0b we=%0b wr=%0d exp %0b/%0b/%0d",
                 i, ld_ready, write_enable, wr, exp_rdy[i], exp_we[i], exp_wr[i]);
      end
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (write_enable !== 1'b1 || wr !== 5'd23 || din !== 32'hD3) begin
      errors++;
      $display("FAIL full_third we=%0b wr=%0d din=%h exp 1/23/d3", write_enable, wr, din);
    end
    next_cycle();
    #1;
    checks++;
    if (write_enable !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_drained we=%0b ready=%0b exp 0/1", write_enable, ld_ready);
    end
  endtask

  task automatic test_corners();
    next_cycle();
    ld_valid = 1; ld_rd = 5'd0; ld_data = 32'hBAD0BAD0;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready got=%0b exp 1", ld_ready);
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (write_enable !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_write we=%0b wr=%0d exp we=0", write_enable, wr);
    end
    issue_valid = 1; issue_is_load = 1; issue_rd = 5'd8;
    next_cycle();
    issue_valid = 0; issue_is_load = 0; issue_rd = '0;
    ld_valid = 1; ld_rd = 5'd8; ld_data = 32'h8888_0001;
    next_cycle();
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    issue_valid = 1; issue_is_load = 1; issue_rd = 5'd8;
    #1;
    checks++;
    if (write_enable !== 1'b1 || wr !== 5'd8 || din !== 32'h8888_0001) begin
      errors++;
      $display("FAIL x8_write we=%0b wr=%0d din=%h exp 1/8/88880001", write_enable, wr, din);
    end
    next_cycle();
    issue_valid = 0; issue_is_load = 0; issue_rd = '0;
    dec_rd = 5'd8;
    #1;
    checks++;
    if (dec_stall !== 1'b1 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL x8_set_wins stall=%0b we=%0b exp 1/0", dec_stall, write_enable);
    end
    ld_valid = 1; ld_rd = 5'd8; ld_data = 32'h8888_0002;
    next_cycle();
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    next_cycle();
    #1;
    checks++;
    if (dec_stall !== 1'b0) begin
      errors++;
      $display("FAIL x8_cleared stall=%0b exp 0", dec_stall);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    next_cycle();
    issue_valid = 1; issue_is_load = 1; issue_rd = 5'd5;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid = 1; ld_rd = 5'd12; ld_data = 32'hC12;
    next_cycle();
    issue_valid = 0; issue_is_load = 0; issue_rd = '0;
    ld_rd = 5'd13; ld_data = 32'hC13;
    next_cycle();
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    dec_rs1 = 5'd5;
    #1;
    checks++;
    if (ld_ready !== 1'b0 || dec_stall !== 1'b1 || wr !== 5'd1) begin
      errors++;
      $display("FAIL rst_setup ready=%0b stall=%0b wr=%0d exp 0/1/1", ld_ready, dec_stall, wr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b0 || ld_ready !== 1'b0 || dec_stall !== 1'b0 || wr !== 5'd0 || din !== 32'd0) begin
      errors++;
      $display("FAIL rst_during we=%0b ready=%0b stall=%0b wr=%0d din=%h exp all 0",
               write_enable, ld_ready, dec_stall, wr, din);
    end
    next_cycle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (write_enable !== 1'b0 || ld_ready !== 1'b1 || dec_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_after we=%0b ready=%0b stall=%0b exp 0/1/0", write_enable, ld_ready, dec_stall);
    end
    next_cycle();
    #1;
    checks++;
    if (write_enable !== 1'b0) begin
      errors++;
      $display("FAIL rst_fifo_empty we=%0b wr=%0d exp we=0", write_enable, wr);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset_initial();
    test_alu();
    test_load_round_trip();
    test_arbitration();
    test_back_to_back();
    test_corners();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback stage sitting directly upstream of the 32x32 register file: merges single-cycle ALU results with buffered, variable-latency load responses into the file's single write port (`wr`, `write_enable`, `din`). Also keeps a per-register busy scoreboard for outstanding loads and gives decode a stall signal for RAW and WAW hazards. Holds a small load-response FIFO so the memory side can deliver data while the ALU owns the port.

## Interface
- `LQ_DEPTH`, default 2: load-response FIFO entries (power of two, at least 2).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `alu_valid`  in  1: ALU result present this cycle; it must be written this cycle and cannot stall.
- `alu_rd`  in  5: ALU destination register.
- `alu_data`  in  32: ALU result.
- `issue_valid`  in  1: an instruction issues this cycle. The issuer guarantees `issue_valid` only when `dec_stall`=0.
- `issue_is_load`  in  1: the issuing instruction is a load.
- `issue_rd`  in  5: destination register of the issuing instruction.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each: registers of the instruction in decode.
- `dec_stall`  out  1: combinational hazard indication.
- `ld_valid`  in  1: a load response is offered.
- `ld_ready`  out  1: the FIFO can accept a load response.
- `ld_rd`  in  5: load destination register.
- `ld_data`  in  32: load data.
- `wr`  out  5: register-file write address.
- `write_enable`  out  1: register-file write strobe.
- `din`  out  32: register-file write data.

## Operation
- **Busy scoreboard.** 32 bits; bit 0 is hardwired to 0.
  - Set at the edge where `issue_valid & issue_is_load & issue_rd!=0`.
  - Cleared at the edge where a FIFO-sourced write to that register commits.
  - If set and clear target the same register in the same cycle, set wins.
- **Stall.** `dec_stall` = `busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]`.
  - Register 0 never stalls.
  - `dec_stall` is stale-safe: it stays high during the cycle in which the write is on the port.
- **Load FIFO.**
  - `ld_ready` = not full. It is registered-state only and does not depend on a same-cycle pop.
  - Push when `ld_valid & ld_ready`.
  - A response with `ld_rd`=0 is accepted (handshake completes) but not enqueued.
  - Entries are kept in order; pointers wrap modulo `LQ_DEPTH`.
- **Write-port arbitration** (combinational, each cycle):
  - If `alu_valid & alu_rd!=0`: `wr`=`alu_rd`, `din`=`alu_data`, `write_enable`=1. The FIFO does not pop.
  - Otherwise, if the FIFO is not empty: `wr`/`din` come from the FIFO head, `write_enable`=1, and the head pops at the edge.
  - Otherwise: `write_enable`=0, `wr`=0, `din`=0.
  - An ALU write to x0 is dropped and does not block a FIFO drain in that cycle.
- **Reset** (`rst`=0, asynchronous):
  - FIFO emptied, pointers and count set to 0, all busy bits cleared.
  - While `rst`=0: `write_enable`=0, `wr`=0, `din`=0, `ld_ready`=0, `dec_stall`=0.
  - After release: `ld_ready`=1.
  - A load outstanding at reset is forgotten; its late response, if accepted, is written normally.

## Timing
- ALU result: 0-cycle latency. `write_enable` is high in the same cycle as `alu_valid`, and the register file captures it at that cycle's edge.
- Load response accepted at edge N: the earliest write is in cycle N+1. Every consecutive cycle with `alu_valid` delays it by one further cycle.
- Busy bit cleared at the edge ending the write cycle. The decode instruction can issue in the following cycle and reads the updated register.
- Full FIFO with a pop in the same cycle: `ld_ready` is still 0 that cycle and becomes 1 in the next cycle.
- Sustained throughput: one write per cycle. The FIFO drains at most one entry per cycle when the ALU is idle.
- Starvation: the FIFO can starve under continuous ALU traffic. This is acceptable; back-pressure goes through `ld_ready`.

## Test plan
- **Reset.** Assert `rst`=0 mid-operation with 2 entries queued and busy[5]=1.
  - During reset: `write_enable`=0 and `ld_ready`=0.
  - After release: FIFO empty, `dec_stall`=0 for `dec_rs1`=5, `ld_ready`=1.
- **ALU path.** `alu_valid`=1, `alu_rd`=3, `alu_data`=0xDEADBEEF → same cycle `wr`=3, `din`=0xDEADBEEF, `write_enable`=1.
  - With `alu_rd`=0 → `write_enable`=0.
- **Load round trip.**
  - Issue a load to x7 → busy[7]=1; `dec_rs2`=7 gives `dec_stall`=1.
  - Response x7=0x12345678 accepted at edge N → write in cycle N+1.
  - `dec_stall` drops in cycle N+2.
- **Arbitration.** Queue loads to x4 and x6, then hold `alu_valid` for 3 cycles (x9, x10, x11).
  - Port order: x9, x10, x11, then x4, x6.
  - `ld_ready`=0 while 2 entries are queued.
- **Full/back-pressure.** With `LQ_DEPTH`=2, offer 3 back-to-back responses while the ALU is busy.
  - The third waits with `ld_valid` held and `ld_ready`=0.
  - It is accepted in the cycle after the first pop; all three write in order with no loss.
- **Corner cases.**
  - `ld_rd`=0 response → accepted, no write.
  - A new load issue to x8 in the same cycle as the x8 load write commits → busy[8] stays 1.
